id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 38 +++
 rtl/id_stage_if.sv | 28 ++
 rtl/id_imm_gen.sv | 28 ++
 rtl/id_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_stage.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32/RV64 integer decode stage: opcodes, funct fields,
// immediate formats and operand-select encodings.
package id_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_D = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_e;

endpackage

// File: rtl/id_stage_if.sv
// Handshake bundles on either side of the decode stage: fetch -> ID and ID -> EX.
interface id_fetch_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;

  modport master (output in_valid, inst_i, inst_addr_i, input in_ready);
  modport slave  (input in_valid, inst_i, inst_addr_i, output in_ready);
endinterface

interface id_ex_if #(parameter int XLEN = 32);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [XLEN-1:0] imm_o;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;
  logic            illegal_o;

  modport master (output out_valid, op1_o, op2_o, imm_o, inst_o, inst_addr_o, rd_addr_o,
                  reg_wen_o, illegal_o, input out_ready);
  modport slave  (input out_valid, op1_o, op2_o, imm_o, inst_o, inst_addr_o, rd_addr_o,
                  reg_wen_o, illegal_o, output out_ready);
endinterface

// File: rtl/id_imm_gen.sv
// Combinational immediate extraction; builds the 32-bit form and sign-extends to XLEN.
module id_imm_gen
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// Decode stage: classifies the fetched instruction, selects operands, detects load-use
// hazards and holds the result in a single valid/ready output register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV_E = 0
) (
  input  logic            clk,
  input  logic            rst,
  id_fetch_if.slave       fetch,
  id_ex_if.master         ex,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  input  logic            ex_load_valid_i,
  input  logic [4:0]      ex_load_rd_i
);

  localparam bit IS_RV64 = (XLEN == 64);
  localparam bit IS_RV_E = (RV_E != 0);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic       uses_rs1, uses_rs2, writes_rd, fn_legal, illegal, stall, in_ready, xfer;
  imm_fmt_e   fmt;
  op1_sel_e   op1_sel;
  op2_sel_e   op2_sel;
  logic [XLEN-1:0] imm_raw, op1_dec, op2_dec, imm_dec;

  logic            out_valid_q, out_valid_d, reg_wen_q, reg_wen_d, illegal_q, illegal_d;
  logic [31:0]     inst_q, inst_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;

  assign opcode = fetch.inst_i[6:0];
  assign funct3 = fetch.inst_i[14:12];
  assign funct7 = fetch.inst_i[31:25];
  assign rs1_f  = fetch.inst_i[19:15];
  assign rs2_f  = fetch.inst_i[24:20];
  assign rd_f   = fetch.inst_i[11:7];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    fn_legal  = 1'b0;
    fmt       = IMM_R;
    op1_sel   = OP1_RS1;
    op2_sel   = OP2_IMM;
    case (opcode)
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
        // shamt is 6 bits on RV64, so funct7[0] belongs to it there
        case (funct3)
          F3_SLL:     fn_legal = (funct7[6:1] == 6'b000000) && (IS_RV64 || !funct7[0]);
          F3_SRL_SRA: fn_legal = (funct7[6:1] == 6'b000000 || funct7[6:1] == 6'b010000) &&
                                 (IS_RV64 || !funct7[0]);
          default:    fn_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; op2_sel = OP2_RS2;
        fn_legal = (funct7 == F7_BASE) ||
                   (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_B; op2_sel = OP2_RS2;
        fn_legal = (funct3 != F3_BR_RSV0) && (funct3 != F3_BR_RSV1);
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
        fn_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU) ||
                   (IS_RV64 && (funct3 == F3_D || funct3 == F3_WU));
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_S; op2_sel = OP2_RS2;
        fn_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (IS_RV64 && funct3 == F3_D);
      end
      OPC_JAL:   begin writes_rd = 1'b1; fmt = IMM_J; op1_sel = OP1_PC;   fn_legal = 1'b1; end
      OPC_JALR:  begin
        uses_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I; fn_legal = (funct3 == F3_JALR);
      end
      OPC_LUI:   begin writes_rd = 1'b1; fmt = IMM_U; op1_sel = OP1_ZERO; fn_legal = 1'b1; end
      OPC_AUIPC: begin writes_rd = 1'b1; fmt = IMM_U; op1_sel = OP1_PC;   fn_legal = 1'b1; end
      default:   fn_legal = 1'b0;
    endcase
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (fetch.inst_i[31:7]),
    .fmt  (fmt),
    .imm  (imm_raw)
  );

  always_comb begin
    illegal = !fn_legal ||
              (IS_RV_E && ((uses_rs1 && rs1_f[4]) || (uses_rs2 && rs2_f[4]) ||
                           (writes_rd && rd_f[4])));
    rs1_addr_o = uses_rs1 ? rs1_f : 5'd0;
    rs2_addr_o = uses_rs2 ? rs2_f : 5'd0;
    stall = fetch.in_valid && ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
            ((uses_rs1 && rs1_f == ex_load_rd_i) || (uses_rs2 && rs2_f == ex_load_rd_i));
    case (op1_sel)
      OP1_RS1: op1_dec = rs1_data_i;
      OP1_PC:  op1_dec = fetch.inst_addr_i;
      default: op1_dec = '0;
    endcase
    op2_dec = (op2_sel == OP2_RS2) ? rs2_data_i : imm_raw;
    imm_dec = imm_raw;
    if (illegal) begin
      op1_dec = '0;
      op2_dec = '0;
      imm_dec = '0;
    end
  end

  assign in_ready       = !rst && (!out_valid_q || ex.out_ready) && !stall && !flush_i;
  assign xfer           = fetch.in_valid && in_ready;
  assign fetch.in_ready = in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    reg_wen_d   = reg_wen_q;
    illegal_d   = illegal_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      inst_d      = fetch.inst_i;
      addr_d      = fetch.inst_addr_i;
      op1_d       = op1_dec;
      op2_d       = op2_dec;
      imm_d       = imm_dec;
      rd_d        = rd_f;
      reg_wen_d   = writes_rd && (rd_f != 5'd0) && !illegal;
      illegal_d   = illegal;
    end else if (ex.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      addr_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      reg_wen_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      addr_q      <= addr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      reg_wen_q   <= reg_wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex.out_valid   = out_valid_q;
  assign ex.inst_o      = inst_q;
  assign ex.inst_addr_o = addr_q;
  assign ex.op1_o       = op1_q;
  assign ex.op2_o       = op2_q;
  assign ex.imm_o       = imm_q;
  assign ex.rd_addr_o   = rd_q;
  assign ex.reg_wen_o   = reg_wen_q;
  assign ex.illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: scoreboarded RV32 instance plus direct checks on RV32E and RV64 instances.
module tb_id_stage;

  typedef struct {
    logic [31:0] inst, addr, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  id_fetch_if #(.XLEN(32)) f32 ();
  id_ex_if    #(.XLEN(32)) x32 ();
  logic [4:0]  rs1a, rs2a, ldrd;
  logic [31:0] rs1d, rs2d;
  logic        flush, ldv;

  id_fetch_if #(.XLEN(32)) fe ();
  id_ex_if    #(.XLEN(32)) xe ();
  logic [4:0]  e_rs1a, e_rs2a;
  logic [31:0] e_rs1d;

  id_fetch_if #(.XLEN(64)) fw ();
  id_ex_if    #(.XLEN(64)) xw ();
  logic [4:0]  w_rs1a, w_rs2a;
  logic [63:0] w_rs1d;

  logic       tie0   = 1'b0;
  logic [4:0] tie0_5 = 5'd0;

  id_stage #(.XLEN(32), .RV_E(0)) u_dut (
    .clk(clk), .rst(rst), .fetch(f32), .ex(x32),
    .rs1_addr_o(rs1a), .rs2_addr_o(rs2a), .rs1_data_i(rs1d), .rs2_data_i(rs2d),
    .flush_i(flush), .ex_load_valid_i(ldv), .ex_load_rd_i(ldrd)
  );

  id_stage #(.XLEN(32), .RV_E(1)) u_dut_e (
    .clk(clk), .rst(rst), .fetch(fe), .ex(xe),
    .rs1_addr_o(e_rs1a), .rs2_addr_o(e_rs2a), .rs1_data_i(e_rs1d), .rs2_data_i(e_rs1d),
    .flush_i(tie0), .ex_load_valid_i(tie0), .ex_load_rd_i(tie0_5)
  );

  id_stage #(.XLEN(64), .RV_E(0)) u_dut_w (
    .clk(clk), .rst(rst), .fetch(fw), .ex(xw),
    .rs1_addr_o(w_rs1a), .rs2_addr_o(w_rs2a), .rs1_data_i(w_rs1d), .rs2_data_i(w_rs1d),
    .flush_i(tie0), .ex_load_valid_i(tie0), .ex_load_rd_i(tie0_5)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, addr, op1, op2, imm,
                              input logic [4:0] rd, input logic wen, ill);
    exp_t e;
    e.inst = inst; e.addr = addr; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, record what EX must see.
  task automatic drive(input logic [31:0] inst, addr, d1, d2, input exp_t e);
    int waited = 0;
    f32.in_valid = 1'b1; f32.inst_i = inst; f32.inst_addr_i = addr; rs1d = d1; rs2d = d2;
    @(negedge clk);
    while (!f32.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!f32.in_ready) begin
      check_eq($sformatf("accept_timeout[%h]", inst), waited, 0);
      f32.in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      step();
      f32.in_valid = 1'b0;
    end
  endtask

  task automatic send_e(input logic [31:0] inst, d1);
    fe.in_valid = 1'b1; fe.inst_i = inst; fe.inst_addr_i = 32'h0; e_rs1d = d1;
    @(negedge clk);
    check_eq("e_in_ready", fe.in_ready, 1);
    step();
    fe.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_w(input logic [31:0] inst, input logic [63:0] addr, d1);
    fw.in_valid = 1'b1; fw.inst_i = inst; fw.inst_addr_i = addr; w_rs1d = d1;
    @(negedge clk);
    check_eq("w_in_ready", fw.in_ready, 1);
    step();
    fw.in_valid = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && x32.out_valid && x32.out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check_eq($sformatf("inst[%h]", mon_e.inst), x32.inst_o, mon_e.inst);
        check_eq($sformatf("addr[%h]", mon_e.inst), x32.inst_addr_o, mon_e.addr);
        check_eq($sformatf("op1[%h]", mon_e.inst), x32.op1_o, mon_e.op1);
        check_eq($sformatf("op2[%h]", mon_e.inst), x32.op2_o, mon_e.op2);
        check_eq($sformatf("imm[%h]", mon_e.inst), x32.imm_o, mon_e.imm);
        check_eq($sformatf("rd[%h]", mon_e.inst), x32.rd_addr_o, mon_e.rd);
        check_eq($sformatf("wen[%h]", mon_e.inst), x32.reg_wen_o, mon_e.wen);
        check_eq($sformatf("ill[%h]", mon_e.inst), x32.illegal_o, mon_e.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    f32.in_valid = 1'b1; f32.inst_i = 32'hFFF08293; f32.inst_addr_i = 32'h0;
    rs1d = 32'd7; rs2d = 32'd0; x32.out_ready = 1'b1;
    flush = 1'b0; ldv = 1'b0; ldrd = 5'd0;
    fe.in_valid = 1'b0; fe.inst_i = 32'h0; fe.inst_addr_i = 32'h0; e_rs1d = 32'h0;
    xe.out_ready = 1'b1;
    fw.in_valid = 1'b0; fw.inst_i = 32'h0; fw.inst_addr_i = 64'h0; w_rs1d = 64'h0;
    xw.out_ready = 1'b1;

    // reset with an instruction already on offer
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", f32.in_ready, 0);
    check_eq("rst_out_valid", x32.out_valid, 0);
    step();
    rst = 1'b0;
    f32.in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", x32.out_valid, 0);
    check_eq("post_rst_op1", x32.op1_o, 0);
    check_eq("post_rst_inst", x32.inst_o, 0);
    step();

    f32.inst_i = 32'hFFF08293;
    #1;
    check_eq("addi_rs1_addr", rs1a, 1);
    check_eq("addi_rs2_addr", rs2a, 0);

    // back-to-back stream over the instruction classes
    drive(32'hFFF08293, 32'h1000, 32'd7, 32'd0,
          mk(32'hFFF08293, 32'h1000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 0));
    drive(32'h00000013, 32'h1004, 32'd0, 32'd0,
          mk(32'h00000013, 32'h1004, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0));
    drive(32'hFE208CE3, 32'h1008, 32'h11, 32'h22,
          mk(32'hFE208CE3, 32'h1008, 32'h11, 32'h22, 32'hFFFFFFF8, 5'd25, 0, 0));
    drive(32'h0020A423, 32'h100C, 32'h300, 32'hABCD,
          mk(32'h0020A423, 32'h100C, 32'h300, 32'hABCD, 32'h8, 5'd8, 0, 0));
    drive(32'h800000B7, 32'h1010, 32'h55, 32'h66,
          mk(32'h800000B7, 32'h1010, 32'h0, 32'h80000000, 32'h80000000, 5'd1, 1, 0));
    drive(32'h00001117, 32'h200, 32'h55, 32'h66,
          mk(32'h00001117, 32'h200, 32'h200, 32'h1000, 32'h1000, 5'd2, 1, 0));
    drive(32'hFFFFFFFF, 32'h204, 32'h5, 32'h6,
          mk(32'hFFFFFFFF, 32'h204, 32'h0, 32'h0, 32'h0, 5'd31, 0, 1));
    drive(32'h022081B3, 32'h208, 32'h5, 32'h6,
          mk(32'h022081B3, 32'h208, 32'h0, 32'h0, 32'h0, 5'd3, 0, 1));
    drive(32'h0020A063, 32'h20C, 32'h5, 32'h6,
          mk(32'h0020A063, 32'h20C, 32'h0, 32'h0, 32'h0, 5'd0, 0, 1));
    step();

    // EX back-pressure: SUB held for three cycles, next ADDI waits
    x32.out_ready = 1'b0;
    drive(32'h402081B3, 32'h300, 32'd10, 32'd3,
          mk(32'h402081B3, 32'h300, 32'd10, 32'd3, 32'd0, 5'd3, 1, 0));
    f32.in_valid = 1'b1; f32.inst_i = 32'hFFF08293; f32.inst_addr_i = 32'h304; rs1d = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_valid", x32.out_valid, 1);
      check_eq("hold_op1", x32.op1_o, 32'd10);
      check_eq("hold_inst", x32.inst_o, 32'h402081B3);
      check_eq("hold_in_ready", f32.in_ready, 0);
      step();
    end
    x32.out_ready = 1'b1;
    drive(32'hFFF08293, 32'h304, 32'd7, 32'd0,
          mk(32'hFFF08293, 32'h304, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 0));
    step();

    // load-use hazard
    ldv = 1'b1; ldrd = 5'd2;
    f32.in_valid = 1'b1; f32.inst_i = 32'h002081B3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("ld_stall", f32.in_ready, 0);
      step();
    end
    ldv = 1'b0;
    drive(32'h002081B3, 32'h400, 32'd4, 32'd9,
          mk(32'h002081B3, 32'h400, 32'd4, 32'd9, 32'd0, 5'd3, 1, 0));
    ldv = 1'b1; ldrd = 5'd0;
    f32.in_valid = 1'b1; f32.inst_i = 32'h000001B3;
    #1;
    check_eq("ld_rd0_no_stall", f32.in_ready, 1);
    drive(32'h000001B3, 32'h404, 32'd0, 32'd0,
          mk(32'h000001B3, 32'h404, 32'd0, 32'd0, 32'd0, 5'd3, 1, 0));
    ldrd = 5'd31;
    f32.in_valid = 1'b1; f32.inst_i = 32'hFFF08293;
    #1;
    check_eq("ld_unused_rs2_no_stall", f32.in_ready, 1);
    ldrd = 5'd5;
    #1;
    check_eq("ld_dest_no_stall", f32.in_ready, 1);
    drive(32'hFFF08293, 32'h408, 32'd7, 32'd0,
          mk(32'hFFF08293, 32'h408, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 0));
    ldrd = 5'd1;
    f32.in_valid = 1'b1; f32.inst_i = 32'hFFF08293;
    #1;
    check_eq("ld_rs1_stall", f32.in_ready, 0);
    ldv = 1'b0; f32.in_valid = 1'b0;
    step();

    // flush with a valid instruction on offer
    f32.in_valid = 1'b1; f32.inst_i = 32'hFFF08293; flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", f32.in_ready, 0);
    step();
    flush = 1'b0; f32.in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_drop_valid", x32.out_valid, 0);
    step();

    // flush kills a held output
    x32.out_ready = 1'b0;
    drive(32'hFFF08293, 32'h500, 32'd7, 32'd0,
          mk(32'hFFF08293, 32'h500, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 0));
    flush = 1'b1;
    @(negedge clk);
    check_eq("pre_flush_valid", x32.out_valid, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_held_valid", x32.out_valid, 0);
    void'(sb.pop_back());
    step();

    // reset kills a held output and clears registers
    drive(32'h402081B3, 32'h600, 32'd10, 32'd3,
          mk(32'h402081B3, 32'h600, 32'd10, 32'd3, 32'd0, 5'd3, 1, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", x32.out_valid, 0);
    check_eq("mid_rst_op1", x32.op1_o, 0);
    check_eq("mid_rst_inst", x32.inst_o, 0);
    check_eq("mid_rst_wen", x32.reg_wen_o, 0);
    void'(sb.pop_back());
    x32.out_ready = 1'b1;
    step();

    // RV32E instance
    send_e(32'h00100A13, 32'd0);
    check_eq("e_x20_illegal", xe.illegal_o, 1);
    check_eq("e_x20_wen", xe.reg_wen_o, 0);
    check_eq("e_x20_op2", xe.op2_o, 0);
    send_e(32'hFFF08293, 32'd7);
    check_eq("e_x5_illegal", xe.illegal_o, 0);
    check_eq("e_x5_wen", xe.reg_wen_o, 1);
    check_eq("e_x5_op1", xe.op1_o, 32'd7);

    // RV64 instance
    send_w(32'h800000B7, 64'h0, 64'h0);
    check_eq("w_lui_op2", xw.op2_o, 64'hFFFFFFFF80000000);
    check_eq("w_lui_op1", xw.op1_o, 64'h0);
    check_eq("w_lui_wen", xw.reg_wen_o, 1);
    send_w(32'hFFDFF0EF, 64'h100, 64'h0);
    check_eq("w_jal_op1", xw.op1_o, 64'h100);
    check_eq("w_jal_imm", xw.imm_o, 64'hFFFFFFFFFFFFFFFC);
    check_eq("w_jal_op2", xw.op2_o, 64'hFFFFFFFFFFFFFFFC);
    check_eq("w_jal_rd", xw.rd_addr_o, 5'd1);

    step();
    check_eq("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
